// File: rtl/alu64_arbiter.sv
// alu64_arbiter: shares one alu64 between two requesters.
// Round-robin grant in IDLE, operands held in registers during EXEC,
// MUL (op 3'b111) stretched to MUL_LAT cycles, result returned on a
// valid/ready response channel tagged with the requester id.
module alu64_arbiter #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'b111;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic [3:0]  r_cnt;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [2:0]  r_op;
    logic        r_id;
    logic [63:0] r_rsp_result;
    logic        r_rsp_zero;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_exec;
    logic [63:0] w_sel_a;
    logic [63:0] w_sel_b;
    logic [2:0]  w_sel_op;

    // A lone requester wins; on a tie the one not granted last time wins.
    assign w_idle   = (r_state == IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_sel_a  = w_grant1 ? req1_a  : req0_a;
    assign w_sel_b  = w_grant1 ? req1_b  : req0_b;
    assign w_sel_op = w_grant1 ? req1_op : req0_op;

    // The shared ALU only sees real operands during EXEC; otherwise ADD 0+0.
    assign w_exec = (r_state == EXEC);
    assign alu_a  = w_exec ? r_a  : 64'd0;
    assign alu_b  = w_exec ? r_b  : 64'd0;
    assign alu_op = w_exec ? r_op : 3'd0;

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = !w_idle;

    // Sequencer: accept in IDLE, count down in EXEC, hold response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_a          <= 64'd0;
            r_b          <= 64'd0;
            r_op         <= 3'd0;
            r_id         <= 1'b0;
            r_rsp_result <= 64'd0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_op         <= w_sel_op;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= (w_sel_op == OP_MUL) ? MUL_CNT : 4'd0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_zero   <= alu_zero;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu64_arbiter.sv
// tb_alu64_arbiter: directed bench for alu64_arbiter with a behavioural
// alu64 stand-in (000 ADD, 001 SUB, 100 XOR, 111 MUL, others simple logic).
module tb_alu64_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0Valid;
    logic        req0Ready;
    logic [63:0] req0A;
    logic [63:0] req0B;
    logic [2:0]  req0Op;
    logic        req1Valid;
    logic        req1Ready;
    logic [63:0] req1A;
    logic [63:0] req1B;
    logic [2:0]  req1Op;
    logic        rspValid;
    logic        rspReady;
    logic        rspId;
    logic [63:0] rspResult;
    logic        rspZero;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [2:0]  aluOp;
    logic [63:0] aluResult;
    logic        aluZero;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    alu64_arbiter #(.MUL_LAT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0Valid),
        .req0_ready (req0Ready),
        .req0_a     (req0A),
        .req0_b     (req0B),
        .req0_op    (req0Op),
        .req1_valid (req1Valid),
        .req1_ready (req1Ready),
        .req1_a     (req1A),
        .req1_b     (req1B),
        .req1_op    (req1Op),
        .rsp_valid  (rspValid),
        .rsp_ready  (rspReady),
        .rsp_id     (rspId),
        .rsp_result (rspResult),
        .rsp_zero   (rspZero),
        .alu_a      (aluA),
        .alu_b      (aluB),
        .alu_op     (aluOp),
        .alu_result (aluResult),
        .alu_zero   (aluZero),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the shared alu64 the arbiter drives.
    always_comb begin
        aluResult = 64'd0;
        case (aluOp)
            3'b000: aluResult = aluA + aluB;
            3'b001: aluResult = aluA - aluB;
            3'b010: aluResult = aluA & aluB;
            3'b011: aluResult = aluA | aluB;
            3'b100: aluResult = aluA ^ aluB;
            3'b101: aluResult = aluA << aluB[5:0];
            3'b110: aluResult = aluA >> aluB[5:0];
            3'b111: aluResult = aluA * aluB;
            default: aluResult = 64'd0;
        endcase
    end
    assign aluZero = (aluResult == 64'd0);

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one requester's operation (id selects the port).
    task automatic applyStimulus(input bit id, input bit valid, input logic [63:0] a,
                                 input logic [63:0] b, input logic [2:0] op);
        if (id == 1'b0) begin
            req0Valid = valid; req0A = a; req0B = b; req0Op = op;
        end else begin
            req1Valid = valid; req1A = a; req1B = b; req1Op = op;
        end
    endtask

    // Hold reset for two cycles, then release right after an edge.
    task automatic doReset();
        req0Valid = 1'b0; req0A = '0; req0B = '0; req0Op = '0;
        req1Valid = 1'b0; req1A = '0; req1B = '0; req1Op = '0;
        rspReady  = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        doReset();
        #1;

        // Reset state
        checkOutput("reset_busy",      64'(busy),      64'd0);
        checkOutput("reset_rsp_valid", 64'(rspValid),  64'd0);
        checkOutput("reset_rsp_id",    64'(rspId),     64'd0);
        checkOutput("reset_result",    rspResult,      64'd0);
        checkOutput("reset_zero",      64'(rspZero),   64'd0);
        checkOutput("reset_alu_op",    64'(aluOp),     64'd0);

        // Single ADD: cycle 0 accept, cycle 2 response
        tick();
        applyStimulus(1'b0, 1'b1, 64'd5, 64'd7, 3'b000);
        #1;
        checkOutput("add_req0_ready_c0", 64'(req0Ready), 64'd1);
        checkOutput("add_req1_ready_c0", 64'(req1Ready), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 3'b000);
        #1;
        checkOutput("add_busy_c1",  64'(busy),     64'd1);
        checkOutput("add_alu_a_c1", aluA,          64'd5);
        checkOutput("add_valid_c1", 64'(rspValid), 64'd0);
        tick();
        checkOutput("add_valid_c2",  64'(rspValid), 64'd1);
        checkOutput("add_result_c2", rspResult,     64'd12);
        checkOutput("add_id_c2",     64'(rspId),    64'd0);
        checkOutput("add_zero_c2",   64'(rspZero),  64'd0);
        checkOutput("add_busy_c2",   64'(busy),     64'd1);
        checkOutput("add_alu_idle",  aluA,          64'd0);
        tick();
        checkOutput("add_busy_c3",   64'(busy),     64'd0);

        // Tie arbitration: alternation 0,1,0 with an accept every 3 cycles
        doReset();
        applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, 3'b000);
        applyStimulus(1'b1, 1'b1, 64'd2, 64'd2, 3'b000);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("tie%0d_ready0", k), 64'(req0Ready), 64'((k % 2) == 0));
            checkOutput($sformatf("tie%0d_ready1", k), 64'(req1Ready), 64'((k % 2) == 1));
            tick();
            tick();
            checkOutput($sformatf("tie%0d_valid", k),  64'(rspValid), 64'd1);
            checkOutput($sformatf("tie%0d_id", k),     64'(rspId),    64'(k % 2));
            checkOutput($sformatf("tie%0d_result", k), rspResult,     ((k % 2) == 0) ? 64'd2 : 64'd4);
            tick();
        end

        // MUL latency: op held in cycles 1..3, response in cycle 4
        doReset();
        applyStimulus(1'b1, 1'b1, 64'd6, 64'd7, 3'b111);
        #1;
        checkOutput("mul_ready1_c0", 64'(req1Ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 3'b000);
        for (int c = 1; c <= 3; c++) begin
            #1;
            checkOutput($sformatf("mul_alu_op_c%0d", c), 64'(aluOp),    64'd7);
            checkOutput($sformatf("mul_valid_c%0d", c),  64'(rspValid), 64'd0);
            tick();
        end
        checkOutput("mul_valid_c4",  64'(rspValid), 64'd1);
        checkOutput("mul_result_c4", rspResult,     64'd42);
        checkOutput("mul_id_c4",     64'(rspId),    64'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd2, 3'b111);
        #1;
        checkOutput("mul2_ready1", 64'(req1Ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 3'b000);
        tick();
        tick();
        tick();
        checkOutput("mul2_valid",  64'(rspValid), 64'd1);
        checkOutput("mul2_result", rspResult,     64'd0);
        checkOutput("mul2_zero",   64'(rspZero),  64'd1);
        tick();

        // Backpressure: SUB 9-9 held with rsp_ready low; req1 waits
        doReset();
        rspReady = 1'b0;
        applyStimulus(1'b0, 1'b1, 64'd9, 64'd9, 3'b001);
        applyStimulus(1'b1, 1'b1, 64'd3, 64'd4, 3'b000);
        #1;
        checkOutput("bp_ready0_c0", 64'(req0Ready), 64'd1);
        checkOutput("bp_ready1_c0", 64'(req1Ready), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 3'b000);
        #1;
        checkOutput("bp_ready1_c1", 64'(req1Ready), 64'd0);
        tick();
        for (int c = 2; c <= 6; c++) begin
            checkOutput($sformatf("bp_valid_c%0d", c),  64'(rspValid),  64'd1);
            checkOutput($sformatf("bp_result_c%0d", c), rspResult,      64'd0);
            checkOutput($sformatf("bp_zero_c%0d", c),   64'(rspZero),   64'd1);
            checkOutput($sformatf("bp_ready1_c%0d", c), 64'(req1Ready), 64'd0);
            tick();
        end
        rspReady = 1'b1;
        #1;
        checkOutput("bp_ready1_c7", 64'(req1Ready), 64'd0);
        tick();
        checkOutput("bp_ready1_c8", 64'(req1Ready), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 3'b000);
        tick();
        checkOutput("bp_req1_valid", 64'(rspValid), 64'd1);
        checkOutput("bp_req1_id",    64'(rspId),    64'd1);
        checkOutput("bp_req1_result", rspResult,    64'd7);
        tick();

        // Reset mid-operation: MUL dropped in EXEC cycle 2
        doReset();
        applyStimulus(1'b0, 1'b1, 64'd3, 64'd5, 3'b111);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 3'b000);
        tick();
        #1;
        checkOutput("rst_pre_alu_op", 64'(aluOp), 64'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",   64'(busy),     64'd0);
        checkOutput("rst_alu_op", 64'(aluOp),    64'd0);
        checkOutput("rst_alu_a",  aluA,          64'd0);
        checkOutput("rst_valid",  64'(rspValid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("rst_no_rsp_%0d", c), 64'(rspValid), 64'd0);
        end
        applyStimulus(1'b0, 1'b1, 64'hF0, 64'hFF, 3'b100);
        #1;
        checkOutput("xor_ready0_c0", 64'(req0Ready), 64'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 3'b000);
        tick();
        checkOutput("xor_valid_c2",  64'(rspValid), 64'd1);
        checkOutput("xor_result_c2", rspResult,     64'h0F);
        checkOutput("xor_id_c2",     64'(rspId),    64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu64_arbiter.md
# alu64_arbiter

Two-port arbiter and sequencer that shares a single `alu64` instance between two requesters, such as the integer execute stage and the address/branch unit. Each requester hands over an operation on a valid/ready handshake. The block grants requesters round-robin, drives the shared ALU from registered operands, and holds MUL for a configurable number of cycles. It returns the registered result and zero flag, tagged with the requester ID, on a valid/ready response channel.

## Interface
- `MUL_LAT`, default 3: number of EXEC cycles for op 3'b111 (MUL). Legal range is 1..15. All other ops take 1 EXEC cycle.

- `clk` in 1: the block's single clock; rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_a` in 64, `req0_b` in 64, `req0_op` in 3: requester 0 operands and ALU op code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the operation (0 or 1).
- `rsp_result` out 64: captured ALU result.
- `rsp_zero` out 1: captured ALU zero flag.
- `alu_a` out 64, `alu_b` out 64, `alu_op` out 3: drive the shared `alu64` inputs.
- `alu_result` in 64, `alu_zero` in 1: shared `alu64` outputs.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The state machine has three states: IDLE, EXEC and RESP.
- **IDLE**
  - The arbiter picks a winner among the asserted `reqN_valid` lines.
  - A single requester wins outright.
  - If both are valid, the requester not granted most recently wins.
  - The `last_grant` pointer resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` is combinational: winner's ready = 1, the other = 0. Both readies are 0 outside IDLE.
  - On accept (valid & ready):
    - latch a, b, op and id;
    - update `last_grant`;
    - load the cycle counter with L-1, where L = `MUL_LAT` if op = 3'b111, else 1;
    - go to EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_op` are driven from the latched registers and held constant for all L cycles.
  - While the counter is non-zero it decrements.
  - When the counter is 0, capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, then go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_result` and `rsp_zero` are stable until the handshake.
  - When `rsp_valid & rsp_ready`, go to IDLE. No new request is accepted in the same cycle.
- Outside EXEC, `alu_a`, `alu_b` and `alu_op` are driven to 0 (ADD 0+0), so the ALU stays quiet.
- All 8 op codes are legal and passed through unmodified; only 3'b111 is multi-cycle.
- Width rules:
  - no arithmetic in this block except the 4-bit counter;
  - results are the `alu64` 64-bit wraparound values, captured verbatim.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state = IDLE, `last_grant` = 1, counter = 0;
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_zero` = 0;
  - `busy` = 0, `alu_*` outputs = 0.
  - `reqN_ready` follows the IDLE rule once `rst_n` is high.
- Reset mid-EXEC or mid-RESP drops the in-flight operation: no response is produced.
- Latency: with the accept in cycle 0, EXEC occupies cycles 1..L, and `rsp_valid` rises in cycle L+1.
  - Non-MUL ops: `rsp_valid` in cycle 2.
  - MUL with `MUL_LAT`=3: `rsp_valid` in cycle 4.
- Throughput: at most one operation per L+2 cycles, reached when `rsp_ready` = 1 as the response appears.
- Requesters must hold a, b and op stable while valid is high and ready is low. A requester may deassert valid before ready without penalty.
- Both requesters valid every IDLE cycle gives strict alternation 0,1,0,1…
- An ungranted valid request waits and is serviced at the next IDLE visit.
- `rsp_ready` low stalls indefinitely in RESP, with no accepts and all outputs frozen.

## Test plan
- **Single ADD:** reset, then req0 with a=5, b=7, op=000. Required: req0_ready high in cycle 0; rsp_valid in cycle 2 with rsp_result=12, rsp_id=0, rsp_zero=0; busy high in cycles 1–2.
- **Tie arbitration:** req0 and req1 both valid every cycle, both op=000, with req0 a=1, b=1 and req1 a=2, b=2; rsp_ready=1. Required: responses in order id 0 (2), then id 1 (4), then id 0, with a new accept every 3 cycles.
- **MUL latency:** `MUL_LAT`=3, req1 with a=6, b=7, op=111. Required: alu_op=111 held during cycles 1–3; rsp_valid in cycle 4 with rsp_result=42 and rsp_id=1. A further run with a=2^63, b=2 returns 0 with rsp_zero=1.
- **Backpressure:** SUB with a=9, b=9, holding rsp_ready=0 for 5 cycles while req1 stays valid. Required: rsp_result=0 and rsp_zero=1 held stable; req1_ready stays 0 throughout; req1 is accepted only after the response handshake completes.
- **Reset mid-operation:** assert rst_n=0 during MUL EXEC cycle 2. Required: all outputs drop to their reset values immediately and no response appears. A subsequent req0 XOR with a=0xF0, b=0xFF returns 0x0F in cycle 2.
